// File: rtl/pulse_meter.sv
// Pulse-width meter: measures the high time of pulse_in in clk cycles and
// holds the result under a valid/ready handshake until it is consumed.
module pulse_meter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pulse_in,
  input  logic                 ready,
  output logic [CNT_WIDTH-1:0] width,
  output logic                 valid,
  output logic                 overflow,
  output logic                 missed,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                 r_s1;
  logic                 r_s2;
  logic                 r_s3;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_ovf;
  logic [CNT_WIDTH-1:0] r_width;
  logic                 r_valid;
  logic                 r_overflow;
  logic                 r_missed;

  logic w_rise;
  logic w_hs;
  logic w_max;

  assign w_rise = r_s2 & ~r_s3;
  assign w_hs   = r_valid & ready;
  assign w_max  = &r_count;

  // Sync flops reset high so a level held across reset is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= pulse_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_rise) w_next = MEASURE;
      MEASURE: if (!r_s2)  w_next = DONE;
      DONE:    if (w_hs)   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_width    <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
      r_missed   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_count <= CNT_WIDTH'(1);
            r_ovf   <= 1'b0;
          end
        end
        MEASURE: begin
          if (r_s2) begin
            if (w_max) r_ovf   <= 1'b1;
            else       r_count <= r_count + 1'b1;
          end else begin
            r_width    <= r_count;
            r_overflow <= r_ovf;
            r_missed   <= 1'b0;
            r_valid    <= 1'b1;
          end
        end
        DONE: begin
          // Handshake wins over a concurrent rising edge
          if (w_hs) begin
            r_valid  <= 1'b0;
            r_missed <= 1'b0;
          end else if (w_rise) begin
            r_missed <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign width    = r_width;
  assign valid    = r_valid;
  assign overflow = r_overflow;
  assign missed   = r_missed;
  assign busy     = (r_state == MEASURE);

endmodule
